insn_fetch: RTL and testbench

INSN_FETCH -- requirements
Module: insn_fetch

---
 rtl/insn_fetch.sv | 103 ++++++++++
 tb/tb_insn_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch.sv
// insn_fetch: single-outstanding instruction fetch unit with redirect, flush and drain handling.
// Define INSN_FETCH_MISALIGN_TRAP_EN to trap misaligned redirect/flush targets instead of masking them.
module insn_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] insn,
    output logic        insn_valid,
    input  logic        dec_ready,
    input  logic        pc_next_sel,
    input  logic [31:0] pc_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] pc,
    output logic        fault
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN, FAULT} state_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
    state_t state;
    logic [31:0] tgt, fpc, npc, hold_pc;
    logic bad_tgt, bad_fpc, hold_bad;
`ifdef INSN_FETCH_MISALIGN_TRAP_EN
    assign tgt = pc_target;
    assign fpc = flush_pc;
    assign bad_tgt = |pc_target[1:0];
    assign bad_fpc = |flush_pc[1:0];
`else
    assign tgt = pc_target & 32'hFFFF_FFFC;
    assign fpc = flush_pc & 32'hFFFF_FFFC;
    assign bad_tgt = 1'b0;
    assign bad_fpc = 1'b0;
`endif
    assign npc = pc_next_sel ? tgt : pc + 32'd4;
    // flush wins over a simultaneous consume/redirect
    assign hold_pc = flush ? fpc : npc;
    assign hold_bad = flush ? bad_fpc : (pc_next_sel & bad_tgt);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc <= RESET_PC;
            mem_addr <= RESET_PC;
            mem_req <= 1'b0;
            insn <= NOP;
            insn_valid <= 1'b0;
            fault <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (flush && bad_fpc) begin
                        state <= FAULT;
                        fault <= 1'b1;
                        mem_req <= 1'b0;
                    end else if (flush) begin
                        pc <= fpc;
                        mem_req <= 1'b1;
                        if (mem_ack || !mem_req) mem_addr <= fpc;
                        else state <= DRAIN;
                    end else if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        insn <= mem_rdata;
                        insn_valid <= 1'b1;
                        mem_req <= 1'b0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush || dec_ready) begin
                        insn_valid <= 1'b0;
                        if (hold_bad) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            pc <= hold_pc;
                            mem_addr <= hold_pc;
                            mem_req <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DRAIN: begin
                    // mem_addr keeps the outstanding address; pc holds the restart point
                    if (flush) pc <= fpc;
                    if (flush && bad_fpc) begin
                        state <= FAULT;
                        fault <= 1'b1;
                        mem_req <= 1'b0;
                    end else if (mem_ack) begin
                        mem_addr <= flush ? fpc : pc;
                        state <= FETCH;
                    end
                end
                FAULT: ;
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_insn_fetch.sv
// tb_insn_fetch: scoreboard bench for insn_fetch; memory model answers requests after a set latency.
module tb_insn_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_ack, insn_valid, dec_ready, pc_next_sel, flush, fault;
    logic [31:0] mem_addr, mem_rdata, insn, pc_target, flush_pc, pc;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int lat, wcnt;
    bit drain;
    logic [31:0] model_addr;

    insn_fetch dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .insn(insn), .insn_valid(insn_valid),
        .dec_ready(dec_ready), .pc_next_sel(pc_next_sel), .pc_target(pc_target),
        .flush(flush), .flush_pc(flush_pc), .pc(pc), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'd0) ? 32'h0010_0093 : {a[23:0], 8'h13};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        mem_ack = mem_req && (wcnt >= lat);
        mem_rdata = mem_ack ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        if (rst_n) begin
            check("req_valid_excl", {31'd0, mem_req & insn_valid}, 32'd0);
            if (insn_valid && dec_ready && !flush) begin
                if (q.size() == 0) check("sb_empty", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    check("insn", insn, e.data);
                    check("pc", pc, e.addr);
                end
                model_addr = pc_next_sel ? (pc_target & 32'hFFFF_FFFC) : model_addr + 32'd4;
            end
            if (mem_req && mem_ack) begin
                if (drain) drain = 1'b0;
                else if (!flush) begin
                    check("addr", mem_addr, model_addr);
                    e.addr = model_addr;
                    e.data = mem_word(model_addr);
                    q.push_back(e);
                end
            end
            if (flush) begin
                if (mem_req && !mem_ack) drain = 1'b1;
                q.delete();
                model_addr = flush_pc & 32'hFFFF_FFFC;
            end
            wcnt = mem_ack ? 0 : (mem_req ? wcnt + 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !insn_valid; i++) tick();
        check("wait_valid", {31'd0, insn_valid}, 32'd1);
    endtask

    task automatic do_flush(input logic [31:0] a);
        flush = 1'b1;
        flush_pc = a;
        tick();
        flush = 1'b0;
    endtask

    task automatic reset_bench();
        q.delete();
        drain = 1'b0;
        wcnt = 0;
        model_addr = 32'd0;
    endtask

    task automatic drain_case(input logic [31:0] a, input logic [31:0] b, input bit twice);
        logic [31:0] old;
        lat = 3;
        dec_ready = 1'b1;
        old = mem_addr;
        tick();
        do_flush(a);
        check("drain_addr", mem_addr, old);
        check("drain_req", {31'd0, mem_req}, 32'd1);
        if (twice) do_flush(b);
        else tick();
        check("drain_addr2", mem_addr, old);
        tick();
        check("post_drain_addr", mem_addr, twice ? b : a);
        check("post_drain_valid", {31'd0, insn_valid}, 32'd0);
        wait_valid(20);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        dec_ready = 1'b0;
        pc_next_sel = 1'b0;
        pc_target = 32'd0;
        flush = 1'b0;
        flush_pc = 32'd0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        lat = 0;
        reset_bench();
        repeat (3) tick();
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_insn", insn, 32'h0000_0013);
        check("rst_valid", {31'd0, insn_valid}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'd0);

        lat = 1;
        dec_ready = 1'b1;
        wait_valid(10);
        check("insn_first", insn, 32'h0010_0093);
        tick();
        check("valid_drop", {31'd0, insn_valid}, 32'd0);
        check("next_addr", mem_addr, 32'd4);

        dec_ready = 1'b0;
        wait_valid(10);
        repeat (5) begin
            tick();
            check("hold_insn", insn, mem_word(32'd4));
            check("hold_pc", pc, 32'd4);
            check("hold_req", {31'd0, mem_req}, 32'd0);
            check("hold_valid", {31'd0, insn_valid}, 32'd1);
        end
        dec_ready = 1'b1;
        tick();

        dec_ready = 1'b0;
        wait_valid(10);
        pc_next_sel = 1'b1;
        pc_target = 32'h0000_0100;
        dec_ready = 1'b1;
        tick();
        pc_next_sel = 1'b0;
        check("redir_addr", mem_addr, 32'h100);

        dec_ready = 1'b0;
        wait_valid(10);
        do_flush(32'hFFFF_FFFC);
        check("flush_hold_valid", {31'd0, insn_valid}, 32'd0);
        check("flush_hold_addr", mem_addr, 32'hFFFF_FFFC);
        wait_valid(10);
        dec_ready = 1'b1;
        tick();
        check("wrap_addr", mem_addr, 32'd0);

        drain_case(32'h40, 32'h0, 1'b0);
        drain_case(32'h60, 32'h80, 1'b1);

        lat = 0;
        do_flush(32'h200);
        check("fa_addr", mem_addr, 32'h200);
        check("fa_valid", {31'd0, insn_valid}, 32'd0);
        check("fa_req", {31'd0, mem_req}, 32'd1);
        wait_valid(10);
        tick();

        dec_ready = 1'b0;
        wait_valid(10);
        pc_next_sel = 1'b1;
        pc_target = 32'h0000_0102;
        dec_ready = 1'b1;
        tick();
        pc_next_sel = 1'b0;
`ifdef INSN_FETCH_MISALIGN_TRAP_EN
        repeat (3) begin
            check("trap_fault", {31'd0, fault}, 32'd1);
            check("trap_req", {31'd0, mem_req}, 32'd0);
            check("trap_valid", {31'd0, insn_valid}, 32'd0);
            tick();
        end
        rst_n = 1'b0;
        reset_bench();
        tick();
        check("trap_clear", {31'd0, fault}, 32'd0);
        rst_n = 1'b1;
        tick();
`else
        check("mis_addr", mem_addr, 32'h100);
        check("mis_fault", {31'd0, fault}, 32'd0);
        wait_valid(10);
        tick();
`endif

        dec_ready = 1'b0;
        wait_valid(10);
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, insn_valid}, 32'd0);
        check("arst_pc", pc, 32'd0);
        check("arst_req", {31'd0, mem_req}, 32'd0);
        check("arst_insn", insn, 32'h0000_0013);
        reset_bench();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rerst_req", {31'd0, mem_req}, 32'd1);
        check("rerst_addr", mem_addr, 32'd0);
        dec_ready = 1'b1;
        wait_valid(10);
        tick();
        check("rerst_next", mem_addr, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
